// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - pipeline stall/flush control and trap entry/exit CSR sequencer
// Optional feature macro: TRAP_EXT_INT_EN (machine external interrupt entry)
module trap_ctrl #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    STALL_WIDTH  = 6,
  parameter logic [ADDR_WIDTH-1:0] CAUSE_ECALL  = 32'd11,
  parameter logic [ADDR_WIDTH-1:0] CAUSE_EXTINT = 32'h8000000B
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   stallreq_id_i,
  input  logic [31:0]            exception_i,
  input  logic [ADDR_WIDTH-1:0]  inst_addr_i,
  input  logic [ADDR_WIDTH-1:0]  mtvec_i,
  input  logic [ADDR_WIDTH-1:0]  mepc_i,
  input  logic [ADDR_WIDTH-1:0]  mstatus_i,
  input  logic                   int_req_i,
  output logic [STALL_WIDTH-1:0] stall_o,
  output logic                   flush_o,
  output logic                   jump_o,
  output logic [ADDR_WIDTH-1:0]  jump_addr_o,
  output logic                   csr_we_o,
  output logic [11:0]            csr_waddr_o,
  output logic [ADDR_WIDTH-1:0]  csr_wdata_o,
  output logic                   busy_o
);

  // pc/if/id held, bubble into exe, older stages keep draining
  localparam logic [STALL_WIDTH-1:0] STALL_FRONT = STALL_WIDTH'(3'b111);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  typedef enum logic [2:0] {
    IDLE,
    E_MEPC,
    E_CAUSE,
    E_STATUS,
    R_STATUS,
    JUMP
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] epc;
  logic [ADDR_WIDTH-1:0] cause;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] status_entry;
  logic [ADDR_WIDTH-1:0] status_exit;

  // Only ecall/mret bits of the id exception vector are meaningful; the low
  // mtvec bits are mode bits and never part of the direct-mode target.
  logic unused_inputs;
`ifdef TRAP_EXT_INT_EN
  assign unused_inputs = &{1'b0, exception_i[31:2], mtvec_i[1:0]};
`else
  assign unused_inputs = &{1'b0, exception_i[31:2], mtvec_i[1:0], int_req_i};
`endif

  // mstatus images: entry saves MIE into MPIE and clears MIE, exit restores MIE and sets MPIE
  always_comb begin
    status_entry    = mstatus_i;
    status_entry[7] = mstatus_i[3];
    status_entry[3] = 1'b0;
    status_exit     = mstatus_i;
    status_exit[3]  = mstatus_i[7];
    status_exit[7]  = 1'b1;
  end

  // Sequencer: accept a trap from IDLE, then step one CSR write per cycle and redirect
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      epc    <= '0;
      cause  <= '0;
      target <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A held id instruction is not yet committed to; wait for the hazard to clear
          if (!stallreq_id_i) begin
`ifdef TRAP_EXT_INT_EN
            if (int_req_i && mstatus_i[3]) begin
              // id instruction has not executed, so mepc points at it for re-execution
              epc   <= inst_addr_i;
              cause <= CAUSE_EXTINT;
              state <= E_MEPC;
            end else
`endif
            if (exception_i[1]) begin
              epc   <= inst_addr_i;
              cause <= CAUSE_ECALL;
              state <= E_MEPC;
            end else if (exception_i[0]) begin
              state <= R_STATUS;
            end
          end
        end
        E_MEPC:   state <= E_CAUSE;
        E_CAUSE:  state <= E_STATUS;
        E_STATUS: begin
          target <= {mtvec_i[ADDR_WIDTH-1:2], 2'b00};
          state  <= JUMP;
        end
        R_STATUS: begin
          target <= mepc_i;
          state  <= JUMP;
        end
        JUMP:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Output decode from state and latched values; only IDLE stall follows id live
  always_comb begin
    stall_o     = '0;
    flush_o     = 1'b0;
    jump_o      = 1'b0;
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    case (state)
      IDLE: begin
        // Gated by reset so every output reads zero while reset is held
        if (rst_n_i && stallreq_id_i) stall_o = STALL_FRONT;
      end
      E_MEPC: begin
        stall_o     = STALL_FRONT;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = epc;
      end
      E_CAUSE: begin
        stall_o     = STALL_FRONT;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause;
      end
      E_STATUS: begin
        stall_o     = STALL_FRONT;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = status_entry;
      end
      R_STATUS: begin
        stall_o     = STALL_FRONT;
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = status_exit;
      end
      JUMP: begin
        // Flushing if_id removes the trapping instruction so IDLE does not re-take it
        flush_o = 1'b1;
        jump_o  = 1'b1;
      end
      default: begin
        stall_o = '0;
      end
    endcase
  end

  assign jump_addr_o = target;
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - randomized and directed self-checking bench for trap_ctrl
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stallreq;
  logic [31:0] exc;
  logic [31:0] inst_addr;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mstatus;
  logic        int_req;
  logic [5:0]  stall;
  logic        flush;
  logic        jump;
  logic [31:0] jump_addr;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        busy;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .stallreq_id_i (stallreq),
    .exception_i   (exc),
    .inst_addr_i   (inst_addr),
    .mtvec_i       (mtvec),
    .mepc_i        (mepc),
    .mstatus_i     (mstatus),
    .int_req_i     (int_req),
    .stall_o       (stall),
    .flush_o       (flush),
    .jump_o        (jump),
    .jump_addr_o   (jump_addr),
    .csr_we_o      (csr_we),
    .csr_waddr_o   (csr_waddr),
    .csr_wdata_o   (csr_wdata),
    .busy_o        (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference model: a pending list of per-cycle actions of the trap in flight
  localparam int K_IDLE = 0, K_MEPC = 1, K_CAUSE = 2, K_ESTAT = 3, K_RSTAT = 4, K_JUMP = 5;
  int          step_q[$];
  logic [31:0] m_epc    = '0;
  logic [31:0] m_cause  = '0;
  logic [31:0] m_target = '0;

  function automatic logic [31:0] entry_status(input logic [31:0] ms);
    return (ms & 32'hFFFF_FF77) | (ms[3] ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] exit_status(input logic [31:0] ms);
    return (ms & 32'hFFFF_FF77) | 32'h80 | (ms[7] ? 32'h8 : 32'h0);
  endfunction

  task automatic check_outputs();
    int          k;
    logic [31:0] e_stall, e_data, e_addr;
    logic        e_we, e_jump, e_busy;
    k       = (step_q.size() == 0) ? K_IDLE : step_q[0];
    e_stall = 32'h7;
    e_we    = 1'b1;
    e_jump  = 1'b0;
    e_busy  = 1'b1;
    e_addr  = 32'h0;
    e_data  = 32'h0;
    case (k)
      K_IDLE:  begin e_stall = stallreq ? 32'h7 : 32'h0; e_we = 1'b0; e_busy = 1'b0; end
      K_MEPC:  begin e_addr = 32'h341; e_data = m_epc; end
      K_CAUSE: begin e_addr = 32'h342; e_data = m_cause; end
      K_ESTAT: begin e_addr = 32'h300; e_data = entry_status(mstatus); end
      K_RSTAT: begin e_addr = 32'h300; e_data = exit_status(mstatus); end
      default: begin e_stall = 32'h0; e_we = 1'b0; e_jump = 1'b1; end
    endcase
    check_val("stall", 32'(stall), e_stall);
    check_val("csr_we", 32'(csr_we), 32'(e_we));
    check_val("jump", 32'(jump), 32'(e_jump));
    check_val("flush", 32'(flush), 32'(e_jump));
    check_val("busy", 32'(busy), 32'(e_busy));
    check_val("jump_addr", jump_addr, m_target);
    if (e_we) begin
      check_val("csr_waddr", 32'(csr_waddr), e_addr);
      check_val("csr_wdata", csr_wdata, e_data);
    end
  endtask

  // Advance the model across one rising edge using the inputs present at that edge
  task automatic model_step();
    int k;
    if (step_q.size() != 0) begin
      k = step_q.pop_front();
      if (k == K_ESTAT) m_target = mtvec & 32'hFFFF_FFFC;
      if (k == K_RSTAT) m_target = mepc;
    end else if (!stallreq) begin
`ifdef TRAP_EXT_INT_EN
      if (int_req && mstatus[3]) begin
        m_epc = inst_addr; m_cause = 32'h8000000B;
        step_q = '{K_MEPC, K_CAUSE, K_ESTAT, K_JUMP};
      end else
`endif
      if (exc[1]) begin
        m_epc = inst_addr; m_cause = 32'd11;
        step_q = '{K_MEPC, K_CAUSE, K_ESTAT, K_JUMP};
      end else if (exc[0]) begin
        step_q = '{K_RSTAT, K_JUMP};
      end
    end
  endtask

  task automatic drive(input logic sr, input logic [31:0] ex, input logic [31:0] ia,
                       input logic [31:0] tv, input logic [31:0] ep, input logic [31:0] ms,
                       input logic ir);
    stallreq = sr; exc = ex; inst_addr = ia; mtvec = tv; mepc = ep; mstatus = ms; int_req = ir;
    #1;
  endtask

  task automatic tick();
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic exp_csr(input string tag, input logic [11:0] a, input logic [31:0] d);
    check_val({tag, "_we"}, 32'(csr_we), 32'h1);
    check_val({tag, "_addr"}, 32'(csr_waddr), 32'(a));
    check_val({tag, "_data"}, csr_wdata, d);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_jump_addr", jump_addr, 32'h0);
    check_val("rst_stall", 32'(stall), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // stall request only
    drive(1, 0, 32'h100, 32'h203, 32'h104, 32'h8, 0);
    check_val("t2_stall", 32'(stall), 32'h7);
    check_val("t2_we", 32'(csr_we), 32'h0);
    check_val("t2_jump", 32'(jump), 32'h0);
    tick();

    // ecall entry
    drive(0, 32'h2, 32'h100, 32'h203, 32'h104, 32'h8, 0);
    tick();
    drive(0, 0, 32'h100, 32'h203, 32'h104, 32'h8, 0);
    exp_csr("t3_mepc", 12'h341, 32'h100);
    tick();
    exp_csr("t3_cause", 12'h342, 32'd11);
    tick();
    exp_csr("t3_status", 12'h300, 32'h80);
    tick();
    check_val("t3_jump", 32'(jump), 32'h1);
    check_val("t3_flush", 32'(flush), 32'h1);
    check_val("t3_jump_addr", jump_addr, 32'h200);
    tick();
    tick();

    // mret
    drive(0, 32'h1, 32'h200, 32'h203, 32'h104, 32'h80, 0);
    tick();
    drive(0, 0, 32'h200, 32'h203, 32'h104, 32'h80, 0);
    exp_csr("t4_status", 12'h300, 32'h88);
    tick();
    check_val("t4_jump", 32'(jump), 32'h1);
    check_val("t4_jump_addr", jump_addr, 32'h104);
    tick();

    // ecall held off by a load-use stall
    drive(1, 32'h2, 32'h100, 32'h203, 32'h104, 32'h8, 0);
    repeat (3) begin
      check_val("t5_busy", 32'(busy), 32'h0);
      tick();
    end
    drive(0, 32'h2, 32'h100, 32'h203, 32'h104, 32'h8, 0);
    tick();
    drive(0, 0, 32'h100, 32'h203, 32'h104, 32'h8, 0);
    repeat (3) tick();
    check_val("t5_jump_addr", jump_addr, 32'h200);
    tick();

`ifdef TRAP_EXT_INT_EN
    drive(0, 32'h2, 32'h180, 32'h203, 32'h104, 32'h8, 1);
    tick();
    drive(0, 0, 32'h180, 32'h203, 32'h104, 32'h8, 1);
    tick();
    exp_csr("t6_cause", 12'h342, 32'h8000000B);
    drive(0, 0, 32'h180, 32'h203, 32'h104, 32'h0, 0);
    repeat (3) tick();
    drive(0, 32'h2, 32'h180, 32'h203, 32'h104, 32'h0, 1);
    tick();
    drive(0, 0, 32'h180, 32'h203, 32'h104, 32'h0, 1);
    tick();
    exp_csr("t6_ecall_cause", 12'h342, 32'd11);
    repeat (3) tick();
`endif

    // reset while the mcause write is on the port
    drive(0, 32'h2, 32'h100, 32'h203, 32'h104, 32'h8, 0);
    tick();
    drive(0, 0, 32'h100, 32'h203, 32'h104, 32'h8, 0);
    tick();
    exp_csr("t1_pre", 12'h342, 32'd11);
    rst_n = 1'b0;
    #1;
    check_val("t1_stall", 32'(stall), 32'h0);
    check_val("t1_we", 32'(csr_we), 32'h0);
    check_val("t1_waddr", 32'(csr_waddr), 32'h0);
    check_val("t1_wdata", csr_wdata, 32'h0);
    check_val("t1_jump", 32'(jump), 32'h0);
    check_val("t1_flush", 32'(flush), 32'h0);
    check_val("t1_jump_addr", jump_addr, 32'h0);
    check_val("t1_busy", 32'(busy), 32'h0);
    step_q.delete();
    m_epc = '0; m_cause = '0; m_target = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 32'h100, 32'h203, 32'h104, 32'h8, 0);
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      int          r;
      logic [31:0] ex;
      r  = int'($urandom_range(0, 9));
      ex = $urandom & 32'hFFFF_FFFC;
      if (r == 0) ex[1] = 1'b1;
      else if (r == 1) ex[0] = 1'b1;
      else if (r == 2) ex[1:0] = 2'b11;
      drive(($urandom_range(0, 3) == 0), ex, $urandom, $urandom, $urandom, $urandom,
            1'($urandom_range(0, 1)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
